// File: rtl/mips_pkg.sv
// Shared types for the MIPS boot/run sequencer: FSM state encoding and word/register widths.
package mips_pkg;

    localparam int WORD_W = 32;
    localparam int RB_AW  = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_IM,
        ST_LOAD_RB,
        ST_CHK,
        ST_RUN,
        ST_DONE,
        ST_ERR
    } boot_state_e;

endpackage

// File: rtl/cpu_boot_loader_run_timer.sv
// Down-counter that bounds how long the core runs; expire_o flags the final cycle of a run window.
module run_timer #(
    parameter int CYCLES = 20,
    parameter int CW     = $clog2(CYCLES + 1)
) (
    input  logic clk_CPU,
    input  logic rst,
    input  logic load_i,
    input  logic en_i,
    output logic expire_o
);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_CPU) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= CW'(CYCLES);
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expire_o = (cnt_q == CW'(1));

endmodule

// File: rtl/cpu_boot_loader.sv
// Boot/run sequencer: streams words into instruction memory then register bank, then runs the core.
// Optional trailing checksum word is enabled by defining LOADER_CHECKSUM_EN.
module cpu_boot_loader
    import mips_pkg::*;
#(
    parameter int IM_DEPTH   = 64,
    parameter int RB_DEPTH   = 32,
    parameter int RUN_CYCLES = 20,
    parameter int IM_AW      = 6
) (
    input  logic              clk_CPU,
    input  logic              rst,
    input  logic              start,
    input  logic [WORD_W-1:0] load_data,
    input  logic              load_valid,
    output logic              load_ready,
    output logic              im_we,
    output logic [IM_AW-1:0]  im_addr,
    output logic [WORD_W-1:0] im_wdata,
    output logic              rb_we,
    output logic [RB_AW-1:0]  rb_addr,
    output logic [WORD_W-1:0] rb_wdata,
    input  logic              halt_req,
    output logic              cpu_rst,
    output logic              cpu_en,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int IDX_W = (IM_AW > RB_AW) ? IM_AW : RB_AW;

    boot_state_e       state_q;
    logic [IDX_W-1:0]  idx_q;
    logic              load_ready_q, im_we_q, rb_we_q;
    logic [IM_AW-1:0]  im_addr_q;
    logic [RB_AW-1:0]  rb_addr_q;
    logic [WORD_W-1:0] im_wdata_q, rb_wdata_q;
    logic              cpu_rst_q, cpu_en_q, busy_q, done_q;
    logic              hs, last_im, last_rb, enter_run, tmr_expire;

    assign hs      = load_ready_q & load_valid;
    assign last_im = (idx_q == IDX_W'(IM_DEPTH - 1));
    assign last_rb = (idx_q == IDX_W'(RB_DEPTH - 1));

`ifdef LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] sum_q;
    logic [WORD_W-1:0] sum_d;
    logic              err_q;
    logic              chk_ok;
    assign sum_d     = sum_q + load_data;
    assign chk_ok    = (load_data == sum_q);
    assign enter_run = (state_q == ST_CHK) && hs && chk_ok;
    assign err       = err_q;
`else
    // A cleared load_ready in LOAD_RB is the drain cycle in which the last write lands.
    assign enter_run = (state_q == ST_LOAD_RB) && !load_ready_q;
    assign err       = 1'b0;
`endif

    run_timer #(.CYCLES(RUN_CYCLES)) u_run_timer (
        .clk_CPU  (clk_CPU),
        .rst      (rst),
        .load_i   (enter_run),
        .en_i     (state_q == ST_RUN),
        .expire_o (tmr_expire)
    );

    always_ff @(posedge clk_CPU) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            load_ready_q <= 1'b0;
            im_we_q      <= 1'b0;
            rb_we_q      <= 1'b0;
            im_addr_q    <= '0;
            rb_addr_q    <= '0;
            im_wdata_q   <= '0;
            rb_wdata_q   <= '0;
            cpu_rst_q    <= 1'b1;
            cpu_en_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q        <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            im_we_q <= 1'b0;
            rb_we_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        state_q      <= ST_LOAD_IM;
                        idx_q        <= '0;
                        load_ready_q <= 1'b1;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        cpu_rst_q    <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
                        sum_q        <= '0;
                        err_q        <= 1'b0;
`endif
                    end
                end
                ST_LOAD_IM: begin
                    if (!load_ready_q) begin
                        state_q      <= ST_LOAD_RB;
                        idx_q        <= '0;
                        load_ready_q <= 1'b1;
                    end else if (load_valid) begin
                        im_we_q    <= 1'b1;
                        im_addr_q  <= idx_q[IM_AW-1:0];
                        im_wdata_q <= load_data;
                        idx_q      <= idx_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                        sum_q      <= sum_d;
`endif
                        if (last_im) load_ready_q <= 1'b0;
                    end
                end
                ST_LOAD_RB: begin
                    if (!load_ready_q) begin
`ifdef LOADER_CHECKSUM_EN
                        state_q      <= ST_CHK;
                        load_ready_q <= 1'b1;
`else
                        state_q   <= ST_RUN;
                        cpu_rst_q <= 1'b0;
                        cpu_en_q  <= 1'b1;
`endif
                    end else if (load_valid) begin
                        rb_we_q    <= 1'b1;
                        rb_addr_q  <= idx_q[RB_AW-1:0];
                        rb_wdata_q <= load_data;
                        idx_q      <= idx_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                        sum_q      <= sum_d;
`endif
                        if (last_rb) load_ready_q <= 1'b0;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                ST_CHK: begin
                    if (hs) begin
                        load_ready_q <= 1'b0;
                        if (chk_ok) begin
                            state_q   <= ST_RUN;
                            cpu_rst_q <= 1'b0;
                            cpu_en_q  <= 1'b1;
                        end else begin
                            state_q <= ST_ERR;
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end
                end
`endif
                ST_RUN: begin
                    if (halt_req || tmr_expire) begin
                        state_q   <= ST_DONE;
                        cpu_en_q  <= 1'b0;
                        cpu_rst_q <= 1'b1;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign load_ready = load_ready_q;
    assign im_we      = im_we_q;
    assign im_addr    = im_addr_q;
    assign im_wdata   = im_wdata_q;
    assign rb_we      = rb_we_q;
    assign rb_addr    = rb_addr_q;
    assign rb_wdata   = rb_wdata_q;
    assign cpu_rst    = cpu_rst_q;
    assign cpu_en     = cpu_en_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
